// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and counter sizing for seq_multiplier
// Contents: state_t (IDLE/CALC/DONE), cnt_width() step-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: a, b, cin -> sum, cout.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - N-bit ripple-carry adder chained from full_adder cells
// Ports: a, b [N-1:0], cin -> sum [N-1:0], cout.
module ripple_adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add multiplier, signed/unsigned, valid/ready handshakes
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, signed_mode;
//        out_valid/out_ready with p [2W-1:0]; busy (CALC or DONE).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int CW = cnt_width(W);

  state_t          state_q, state_d;
  logic [CW-1:0]   step_q;
  logic            steps_done_q;
  logic [W:0]      mcand_q;
  logic [W:0]      hi_q;
  logic [W-1:0]    lo_q;
  logic            neg_q;

  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      addend, sum;
  logic            cout;
  logic [2*W-1:0]  mag;
  logic            unused_hi_msb;

  // Negating a W-bit two's-complement value and reading it back unsigned
  // gives the exact magnitude, including -2^(W-1) -> 2^(W-1).
  assign a_mag = (signed_mode && a[W-1]) ? W'(-a) : a;
  assign b_mag = (signed_mode && b[W-1]) ? W'(-b) : b;

  assign addend = lo_q[0] ? mcand_q : '0;

  ripple_adder #(.N(W+1)) u_add (
    .a    (hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Magnitude never exceeds 2W bits, so the top accumulator bit is always zero.
  assign mag           = {hi_q[W-1:0], lo_q};
  assign unused_hi_msb = hi_q[W];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)     state_d = ST_CALC;
      ST_CALC: if (steps_done_q) state_d = ST_DONE;
      ST_DONE: if (out_ready)    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // CALC runs W shift-add steps, then one extra cycle applies the sign
  // and loads p, giving the W+1 cycle accept-to-valid latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q       <= '0;
      steps_done_q <= 1'b0;
      mcand_q      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      neg_q        <= 1'b0;
      p            <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_q      <= {1'b0, a_mag};
            hi_q         <= '0;
            lo_q         <= b_mag;
            neg_q        <= signed_mode & (a[W-1] ^ b[W-1]);
            step_q       <= '0;
            steps_done_q <= 1'b0;
          end
        end
        ST_CALC: begin
          if (!steps_done_q) begin
            hi_q <= {cout, sum[W:1]};
            lo_q <= {sum[0], lo_q[W-1:1]};
            if (step_q == CW'(W-1)) begin
              step_q       <= '0;
              steps_done_q <= 1'b1;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end else begin
            p            <= neg_q ? -mag : mag;
            steps_done_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (W=4)
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int tests = 0;
  int fails = 0;

  seq_multiplier #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands as interpreted by the mode.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    int xi, yi;
    xi = sm ? int'($signed(x)) : int'(x);
    yi = sm ? int'($signed(y)) : int'(y);
    return (2*W)'(xi * yi);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 16'(in_ready), 16'd1);
  endtask

  // One operation: stall = cycles out_ready is held low once out_valid rises;
  // scramble = change operands after accept; pulse = in_valid glitch during CALC.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsm,
                       input int stall, input bit scramble, input bit pulse, input bit full);
    logic [2*W-1:0] exp;
    int k;
    exp = ref_prod(ta, tb, tsm);
    wait_ready();
    a = ta; b = tb; signed_mode = tsm; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); signed_mode = ~tsm;
    end
    for (k = 1; k <= 20; k++) begin
      if (pulse && k == 2) begin a = 1; b = 1; in_valid = 1'b1; end
      if (pulse && k == 3) in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid) break;
      if (full && k == 1) begin
        check("calc_in_ready", 16'(in_ready), 16'd0);
        check("calc_busy", 16'(busy), 16'd1);
      end
    end
    check($sformatf("latency %0h*%0h m%0d", ta, tb, tsm), 16'(k), 16'(W + 1));
    check($sformatf("p %0h*%0h m%0d", ta, tb, tsm), 16'(p), 16'(exp));
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 16'(out_valid), 16'd1);
      check("stall_in_ready", 16'(in_ready), 16'd0);
      check("stall_p", 16'(p), 16'(exp));
      @(posedge clk);
      #1;
    end
    if (full) begin
      out_ready = 1'b1;
      if (stall > 0) begin
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      check("idle_in_ready", 16'(in_ready), 16'd1);
      check("idle_out_valid", 16'(out_valid), 16'd0);
      check("idle_busy", 16'(busy), 16'd0);
      check("idle_p_hold", 16'(p), 16'(exp));
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '1; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_p", 16'(p), 16'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    do_op(4'd15, 4'd15, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_op(4'b1000, 4'b1000, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    do_op(4'd13, 4'd5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    do_op(4'd7, 4'd6, 1'b0, 3, 1'b0, 1'b0, 1'b1);
    do_op(4'd0, 4'd9, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_op(4'd9, 4'd9, 1'b0, 0, 1'b1, 1'b1, 1'b1);

    // No second product from the ignored in_valid pulse.
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_extra_product", 16'(seen), 16'd0);

    // Reset while in CALC step 2, with in_valid held high during reset.
    wait_ready();
    a = 4'd11; b = 4'd13; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_p", 16'(p), 16'd0);
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    check("midrst_quiet", 16'(seen), 16'd0);

    for (int r = 0; r < 24; r++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'b1, 1'b0, 1'b1);

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 256; i++)
        do_op(W'(i >> 4), W'(i), 1'(m), 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: W, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operand pair and mode present on a, b, signed_mode.
REQ-005 Port: in_ready  output  1  block can accept a new operand pair.
REQ-006 Port: a  input  W  multiplicand.
REQ-007 Port: b  input  W  multiplier.
REQ-008 Port: signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned.
REQ-009 Port: out_valid  output  1  p holds a completed product.
REQ-010 Port: out_ready  input  1  consumer accepts p this cycle.
REQ-011 Port: p  output  2W  product.
REQ-012 Port: busy  output  1  high in CALC and DONE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE SHALL drive in_ready=1, out_valid=0 and busy=0.
REQ-015 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; a, b and signed_mode SHALL be captured then; FSM -> CALC.
REQ-016 At capture in signed_mode, operands SHALL be converted to magnitudes (W+1-bit internal, so -2^(W-1) is exact), and the result sign SHALL be sign(a) XOR sign(b).
REQ-017 CALC SHALL perform one shift-add step per cycle (LSB-first on the multiplier magnitude) for exactly W cycles; a step counter SHALL count 0..W-1.
REQ-018 After the W-th step the FSM SHALL move to DONE; the 2W-bit magnitude SHALL be negated when the result sign is 1, then registered onto p.
REQ-019 Latency: for an accept at edge t, out_valid SHALL first be 1 after edge t+W+1.
REQ-020 DONE SHALL hold out_valid=1 and p stable until out_ready=1 at a rising edge; FSM -> IDLE on that edge.
REQ-021 in_ready SHALL be 0 in CALC and DONE; in_valid in those states SHALL be ignored, with no capture.
REQ-022 p SHALL hold its last value in IDLE and CALC; it changes only on the CALC->DONE transition or at reset.
REQ-023 Unsigned result SHALL be exact for all inputs (max (2^W-1)^2 fits 2W bits); signed result SHALL be exact two's-complement for all inputs, including (-2^(W-1))^2.
REQ-024 A zero operand SHALL still take the full W CALC cycles; no early termination.
REQ-025 Changes on a, b or signed_mode after accept SHALL NOT affect the product in flight.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, step counter=0, p=0, out_valid=0, busy=0, in_ready=1 on the following cycle, from any state.
REQ-027 Reset mid-CALC or mid-DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-028 While rst_n=0, in_valid SHALL be ignored.

Structure
REQ-029 State encodings and the counter-width function (clog2 of W) SHALL live in a shared package/include mult_pkg.
REQ-030 The partial-product accumulate SHALL be one sub-module, ripple_adder (parametrised W+1-bit ripple-carry adder built from the existing full_adder cell); no other sub-modules.

Verification
REQ-031 W=4, unsigned, a=15, b=15, out_ready=1 -> out_valid rises 5 cycles after accept, p=8'hE1 (225).
REQ-032 W=4, signed, a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40 (64); a=-3, b=5 -> p=8'hF1 (-15).
REQ-033 Backpressure: W=4, a=7, b=6 unsigned, out_ready=0 for 3 cycles after out_valid -> p=8'h2A held stable with out_valid=1, in_ready=0; IDLE the cycle after out_ready=1.
REQ-034 in_valid pulsed with a=1, b=1 during CALC of 9*9 -> result p=8'h51 (81) and no second product produced.
REQ-035 rst_n=0 for one cycle at CALC step 2 -> next cycle in_ready=1, busy=0, p=0; no out_valid until a new accept.
REQ-036 Exhaustive sweep W=4, both modes, all 256 operand pairs each, back-to-back accepts -> every p matches the reference model and each latency equals W+1.
